// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Purpose:
//   Shares one combinational RV32I ALU between two requesters.
//   - Port 0: execute-stage issue path.
//   - Port 1: auxiliary client, such as the CSR or address-generation path.
//   The winning request is latched into the registered ALU drive and the ALU
//   is allowed one cycle (EXEC). Its result is then captured and held in
//   RESP until the owning port accepts it.
//
// Configuration macro:
//   ALU_ARB_ROUND_ROBIN_EN
//     Defined   : ties are broken round-robin through the 'last' pointer.
//     Undefined : fixed priority. Port 0 wins every tie, so port 1 can
//                 starve while port 0 stays valid.
//
// Ports:
//   clk                     in   rising-edge clock
//   reset_n                 in   asynchronous active-low reset
//   req0_valid/req1_valid   in   request present
//   req0_op/req1_op         in   ALU operation code (OPW bits)
//   req0_a/req0_b           in   port 0 operands (XLEN bits)
//   req1_a/req1_b           in   port 1 operands (XLEN bits)
//   req0_ready/req1_ready   out  request accepted this cycle
//                                (combinational, at most one high)
//   resp0_valid/resp1_valid out  result held for that port
//   resp0_ready/resp1_ready in   port consumes the result
//   resp_result             out  captured ALU result, shared by both ports
//   resp_zero               out  captured ALU zero flag
//   alu_op/alu_a/alu_b      out  registered drive to the shared ALU
//   alu_result/alu_zero     in   combinational ALU outputs
//   busy                    out  transaction in flight (EXEC or RESP)
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int XLEN = 32,
  parameter int OPW  = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req0_valid,
  input  logic [OPW-1:0]  req0_op,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [OPW-1:0]  req1_op,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  output logic            req1_ready,
  output logic            resp0_valid,
  input  logic            resp0_ready,
  output logic            resp1_valid,
  input  logic            resp1_ready,
  output logic [XLEN-1:0] resp_result,
  output logic            resp_zero,
  output logic [OPW-1:0]  alu_op,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  output logic            busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_own;
  logic            w_own_nxt;
`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic            r_last;
`endif

  logic            w_own_ready;
  logic            w_arb_en;
  logic            w_any_valid;
  logic            w_win;
  logic            w_accept;

  logic [OPW-1:0]  r_alu_op;
  logic [XLEN-1:0] r_alu_a;
  logic [XLEN-1:0] r_alu_b;
  logic [XLEN-1:0] r_resp_result;
  logic            r_resp_zero;
  logic            r_resp0_valid;
  logic            r_resp1_valid;
  logic            r_busy;

  // Handshake of the port that currently owns the held response.
  always_comb begin
    w_own_ready = 1'b0;
    if (r_own) begin
      w_own_ready = resp1_ready;
    end else begin
      w_own_ready = resp0_ready;
    end
  end

  // Arbitration window: IDLE, or RESP in the cycle the response is consumed.
  // reset_n gates it so no request is ever accepted while reset is held.
  always_comb begin
    w_arb_en = 1'b0;
    case (r_state)
      ST_IDLE: w_arb_en = reset_n;
      ST_EXEC: w_arb_en = 1'b0;
      ST_RESP: w_arb_en = reset_n & w_own_ready;
      default: w_arb_en = 1'b0;
    endcase
  end

  // Winner selection. A single valid port always wins; ties depend on build.
  always_comb begin
    w_win = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      w_win = ~r_last;
`else
      w_win = 1'b0;
`endif
    end else if (req1_valid) begin
      w_win = 1'b1;
    end else begin
      w_win = 1'b0;
    end
  end

  assign w_any_valid = req0_valid | req1_valid;
  assign w_accept    = w_arb_en & w_any_valid;
  assign req0_ready  = w_accept & ~w_win;
  assign req1_ready  = w_accept &  w_win;

  // Next-state and next-owner decode.
  always_comb begin
    w_state_nxt = r_state;
    w_own_nxt   = r_own;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_EXEC;
          w_own_nxt   = w_win;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_EXEC: begin
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        // Consumption and a fresh acceptance may share this cycle.
        if (w_accept) begin
          w_state_nxt = ST_EXEC;
          w_own_nxt   = w_win;
        end else if (w_own_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: begin
        // Unreachable encoding: recover to a clean idle.
        w_state_nxt = ST_IDLE;
        w_own_nxt   = 1'b0;
      end
    endcase
  end

  // FSM state, owner and status outputs. The status outputs are registered
  // from the next-state decode so they line up with r_state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_own         <= 1'b0;
      r_busy        <= 1'b0;
      r_resp0_valid <= 1'b0;
      r_resp1_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_own         <= w_own_nxt;
      r_busy        <= (w_state_nxt != ST_IDLE);
      r_resp0_valid <= (w_state_nxt == ST_RESP) & ~w_own_nxt;
      r_resp1_valid <= (w_state_nxt == ST_RESP) &  w_own_nxt;
    end
  end

`ifdef ALU_ARB_ROUND_ROBIN_EN
  // Round-robin pointer. Reset to 1 so that port 0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last <= 1'b1;
    end else if (w_accept) begin
      r_last <= w_win;
    end else begin
      r_last <= r_last;
    end
  end
`endif

  // ALU drive registers. They load only on acceptance and otherwise keep the
  // last operation, so the ALU inputs do not toggle while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_alu_op <= {OPW{1'b0}};
      r_alu_a  <= {XLEN{1'b0}};
      r_alu_b  <= {XLEN{1'b0}};
    end else if (w_accept) begin
      if (w_win) begin
        r_alu_op <= req1_op;
        r_alu_a  <= req1_a;
        r_alu_b  <= req1_b;
      end else begin
        r_alu_op <= req0_op;
        r_alu_a  <= req0_a;
        r_alu_b  <= req0_b;
      end
    end else begin
      r_alu_op <= r_alu_op;
      r_alu_a  <= r_alu_a;
      r_alu_b  <= r_alu_b;
    end
  end

  // Result capture at the end of EXEC. The value is held through RESP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_resp_result <= {XLEN{1'b0}};
      r_resp_zero   <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_resp_result <= alu_result;
      r_resp_zero   <= alu_zero;
    end else begin
      r_resp_result <= r_resp_result;
      r_resp_zero   <= r_resp_zero;
    end
  end

  assign alu_op      = r_alu_op;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign resp_result = r_resp_result;
  assign resp_zero   = r_resp_zero;
  assign resp0_valid = r_resp0_valid;
  assign resp1_valid = r_resp1_valid;
  assign busy        = r_busy;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a table of single-port operations
// followed by hand-written arbitration, back-pressure, drop and reset sequences.
module tb_alu_arbiter;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;

  logic        clk;
  logic        reset_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        resp0_valid, resp1_valid, resp0_ready, resp1_ready;
  logic [31:0] resp_result;
  logic        resp_zero;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_zero;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  alu_arbiter #(.XLEN(32), .OPW(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_result(resp_result), .resp_zero(resp_zero),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the shared combinational ALU.
  always_comb begin
    alu_result = 32'd0;
    case (alu_op)
      OP_ADD:  alu_result = alu_a + alu_b;
      OP_SUB:  alu_result = alu_a - alu_b;
      OP_AND:  alu_result = alu_a & alu_b;
      OP_OR:   alu_result = alu_a | alu_b;
      OP_XOR:  alu_result = alu_a ^ alu_b;
      OP_SLT:  alu_result = {31'd0, ($signed(alu_a) < $signed(alu_b))};
      OP_SLTU: alu_result = {31'd0, (alu_a < alu_b)};
      default: alu_result = 32'd0;
    endcase
  end
  assign alu_zero = (alu_result == 32'd0);

  typedef struct {
    logic        port;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = 4'd0; req1_op = 4'd0;
    req0_a = 32'd0; req0_b = 32'd0; req1_a = 32'd0; req1_b = 32'd0;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    #1 reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // One isolated transaction; entered and left just after a rising edge.
  task automatic run_single(input logic port, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] res, input logic zero);
    if (port) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
    @(negedge clk);
    chk("accept_ready0", {31'd0, req0_ready}, {31'd0, ~port});
    chk("accept_ready1", {31'd0, req1_ready}, {31'd0, port});
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("exec_alu_op", {28'd0, alu_op}, {28'd0, op});
    chk("exec_alu_a", alu_a, a);
    chk("exec_alu_b", alu_b, b);
    chk("exec_busy", {31'd0, busy}, 32'd1);
    chk("exec_no_resp", {30'd0, resp1_valid, resp0_valid}, 32'd0);
    tick();
    chk("resp_valid", {30'd0, resp1_valid, resp0_valid}, port ? 32'd2 : 32'd1);
    chk("resp_result", resp_result, res);
    chk("resp_zero", {31'd0, resp_zero}, {31'd0, zero});
    if (port) resp1_ready = 1'b1; else resp0_ready = 1'b1;
    tick();
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    chk("done_no_resp", {30'd0, resp1_valid, resp0_valid}, 32'd0);
    chk("done_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       exp_grant;
    logic [1:0] exp_rdy;

    vecs[0] = '{1'b0, OP_ADD,  32'd5,          32'd7,          32'd12,         1'b0};
    vecs[1] = '{1'b1, OP_SUB,  32'd9,          32'd9,          32'd0,          1'b1};
    vecs[2] = '{1'b0, OP_AND,  32'hF0F0_00FF,  32'h0FF0_FF0F,  32'h00F0_000F,  1'b0};
    vecs[3] = '{1'b1, OP_OR,   32'h1200_0000,  32'h0000_0034,  32'h1200_0034,  1'b0};
    vecs[4] = '{1'b0, OP_XOR,  32'hDEAD_BEEF,  32'hDEAD_BEEF,  32'd0,          1'b1};
    vecs[5] = '{1'b1, OP_SLT,  32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0};
    vecs[6] = '{1'b0, OP_SLTU, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1};
    vecs[7] = '{1'b1, OP_ADD,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1};

    // Reset state, with a request held during reset that must not be taken.
    clear_inputs();
    reset_n = 1'b0;
    req0_valid = 1'b1;
    #12;
    chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    chk("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
    chk("rst_resp_valid", {30'd0, resp1_valid, resp0_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
    chk("rst_result", resp_result, 32'd0);
    chk("rst_zero", {31'd0, resp_zero}, 32'd0);
    req0_valid = 1'b0;
    #1 reset_n = 1'b1;
    tick();

    // Table of single-port operations.
    for (int i = 0; i < 8; i++) begin
      run_single(vecs[i].port, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].zero);
    end

    // Both ports valid continuously, both consumers always ready.
    do_reset();
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 32'd1; req0_b = 32'd1;
    req1_valid = 1'b1; req1_op = OP_ADD; req1_a = 32'd2; req1_b = 32'd2;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
`ifdef ALU_ARB_ROUND_ROBIN_EN
      exp_grant = ((i / 2) % 2) == 1;
`else
      exp_grant = 1'b0;
`endif
      if ((i % 2) == 0) begin
        exp_rdy = exp_grant ? 2'b10 : 2'b01;
      end else begin
        exp_rdy = 2'b00;
      end
      chk("tie_grant", {30'd0, req1_ready, req0_ready}, {30'd0, exp_rdy});
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (busy) tick();
    end
    chk("tie_drained", {31'd0, busy}, 32'd0);
    resp0_ready = 1'b0; resp1_ready = 1'b0;

    // Port 1 result held under back-pressure while port 0 waits.
    req1_valid = 1'b1; req1_op = OP_SUB; req1_a = 32'd9; req1_b = 32'd9;
    @(negedge clk);
    chk("bp_accept1", {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 32'd1; req0_b = 32'd2;
    @(negedge clk);
    chk("bp_exec_no_ready0", {31'd0, req0_ready}, 32'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_resp1_valid", {30'd0, resp1_valid, resp0_valid}, 32'd2);
      chk("bp_result", resp_result, 32'd0);
      chk("bp_zero", {31'd0, resp_zero}, 32'd1);
      chk("bp_no_ready0", {31'd0, req0_ready}, 32'd0);
      tick();
    end
    resp1_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready0_on_consume", {31'd0, req0_ready}, 32'd1);
    chk("bp_still_valid1", {31'd0, resp1_valid}, 32'd1);
    tick();
    resp1_ready = 1'b0; req0_valid = 1'b0;
    chk("bp_exec_a", alu_a, 32'd1);
    chk("bp_exec_b", alu_b, 32'd2);
    chk("bp_resp1_cleared", {30'd0, resp1_valid, resp0_valid}, 32'd0);
    tick();
    chk("bp_resp0", {30'd0, resp1_valid, resp0_valid}, 32'd1);
    chk("bp_result0", resp_result, 32'd3);
    resp0_ready = 1'b1;
    tick();
    resp0_ready = 1'b0;
    chk("bp_idle", {31'd0, busy}, 32'd0);

    // Port 0 valid for one EXEC cycle only: never issued.
    req1_valid = 1'b1; req1_op = OP_AND; req1_a = 32'h0000_00FF; req1_b = 32'h0000_000F;
    @(negedge clk);
    chk("drop_accept1", {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 32'd100; req0_b = 32'd1;
    @(negedge clk);
    chk("drop_no_ready0", {31'd0, req0_ready}, 32'd0);
    tick();
    req0_valid = 1'b0;
    resp1_ready = 1'b1;
    @(negedge clk);
    chk("drop_no_ready0_resp", {31'd0, req0_ready}, 32'd0);
    chk("drop_resp1", {30'd0, resp1_valid, resp0_valid}, 32'd2);
    chk("drop_result", resp_result, 32'h0000_000F);
    tick();
    resp1_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("drop_no_resp0", {31'd0, resp0_valid}, 32'd0);
      chk("drop_idle", {31'd0, busy}, 32'd0);
      chk("drop_alu_a_kept", alu_a, 32'h0000_00FF);
      tick();
    end

    // Reset pulled mid-EXEC.
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 32'd20; req0_b = 32'd22;
    @(negedge clk);
    chk("mid_accept0", {31'd0, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    chk("mid_in_exec", {31'd0, busy}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_resp", {30'd0, resp1_valid, resp0_valid}, 32'd0);
    chk("mid_rst_alu_a", alu_a, 32'd0);
    chk("mid_rst_alu_b", alu_b, 32'd0);
    chk("mid_rst_result", resp_result, 32'd0);
    chk("mid_rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("mid_no_stale_resp", {30'd0, resp1_valid, resp0_valid}, 32'd0);
      chk("mid_idle", {31'd0, busy}, 32'd0);
      tick();
    end
    run_single(1'b0, OP_ADD, 32'd20, 32'd22, 32'd42, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
